// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data requester and memory port signals of the shared memory arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
               mem_addr, mem_wdata, mem_re, mem_we, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
               mem_addr, mem_wdata, mem_re, mem_we, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter for the shared fetch/data memory port
// Fixed-length transactions: ISSUE strobe, MEM_LAT-cycle wait, one-cycle done with registered read data.
module mem_port_arbiter #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             owner;       // 0 = fetch, 1 = data
    logic             last_owner;
    logic             we_l;
    logic             pick_d;

    // On a tie the requester that did not win last time goes first.
    assign pick_d = bus.d_req && (!bus.if_req || !last_owner);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            owner         <= 1'b0;
            last_owner    <= 1'b1;
            we_l          <= 1'b0;
            bus.mem_addr  <= {ADDR_W{1'b0}};
            bus.mem_wdata <= {DATA_W{1'b0}};
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.if_gnt    <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.if_done   <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.if_rdata  <= {DATA_W{1'b0}};
            bus.d_rdata   <= {DATA_W{1'b0}};
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        owner      <= pick_d;
                        last_owner <= pick_d;
                        we_l       <= pick_d && bus.d_we;
                        if (pick_d) begin
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                        end else begin
                            bus.mem_addr  <= bus.if_addr;
                        end
                        bus.if_gnt <= !pick_d;
                        bus.d_gnt  <= pick_d;
                        bus.mem_re <= !(pick_d && bus.d_we);
                        bus.mem_we <= pick_d && bus.d_we;
                        bus.busy   <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    bus.if_gnt <= 1'b0;
                    bus.d_gnt  <= 1'b0;
                    bus.mem_re <= 1'b0;
                    bus.mem_we <= 1'b0;
                    cnt        <= CNT_W'(MEM_LAT - 1);
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        if (!we_l) begin
                            if (owner) bus.d_rdata  <= bus.mem_rdata;
                            else       bus.if_rdata <= bus.mem_rdata;
                        end
                        bus.if_done <= !owner;
                        bus.d_done  <= owner;
                        state       <= S_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    bus.if_done <= 1'b0;
                    bus.d_done  <= 1'b0;
                    bus.busy    <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed checks of mem_port_arbiter at MEM_LAT=2 and MEM_LAT=1
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    mem_port_arbiter_if #(.ADDR_W(13), .DATA_W(8)) bus ();
    mem_port_arbiter_if #(.ADDR_W(13), .DATA_W(8)) bus2 ();

    mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .MEM_LAT(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
    mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .MEM_LAT(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address; data is valid only MEM_LAT cycles after mem_re.
    function automatic logic [7:0] mem_f(input logic [12:0] a);
        return a[7:0] ^ 8'hB5 ^ {3'b000, a[12:8]};
    endfunction

    logic [1:0] v1;
    logic       v2;
    logic [7:0] d1a, d1b, d2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 2'b00;
            v2 <= 1'b0;
        end else begin
            v1  <= {v1[0], bus.mem_re};
            d1a <= mem_f(bus.mem_addr);
            d1b <= d1a;
            v2  <= bus2.mem_re;
            d2  <= mem_f(bus2.mem_addr);
        end
    end
    assign bus.mem_rdata  = v1[1] ? d1b : 8'hEE;
    assign bus2.mem_rdata = v2 ? d2 : 8'hEE;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if ({bus.busy, bus.if_gnt, bus.d_gnt, bus.if_done, bus.d_done, bus.mem_re, bus.mem_we} !== 7'b0)
            $display("FAIL reset_flags: got %b expected 0000000", {bus.busy, bus.if_gnt, bus.d_gnt, bus.if_done, bus.d_done, bus.mem_re, bus.mem_we}); else passed++;
        checks++; if (bus.mem_addr !== 13'h0000) $display("FAIL reset_mem_addr: got %h expected 0000", bus.mem_addr); else passed++;
        checks++; if (bus.mem_wdata !== 8'h00) $display("FAIL reset_mem_wdata: got %h expected 00", bus.mem_wdata); else passed++;
        checks++; if ({bus.if_rdata, bus.d_rdata} !== 16'h0000) $display("FAIL reset_rdata: got %h expected 0000", {bus.if_rdata, bus.d_rdata}); else passed++;
        checks++; if ({bus2.busy, bus2.mem_re, bus2.mem_we, bus2.d_gnt} !== 4'b0) $display("FAIL reset_dut2: got %b expected 0000", {bus2.busy, bus2.mem_re, bus2.mem_we, bus2.d_gnt}); else passed++;
    endtask

    task automatic test_single_fetch();
        bus.if_req  = 1'b1;
        bus.if_addr = 13'h0010;
        tick();
        checks++; if ({bus.if_gnt, bus.d_gnt} !== 2'b10) $display("FAIL fetch_gnt: got %b expected 10", {bus.if_gnt, bus.d_gnt}); else passed++;
        checks++; if ({bus.mem_re, bus.mem_we} !== 2'b10) $display("FAIL fetch_strobe: got %b expected 10", {bus.mem_re, bus.mem_we}); else passed++;
        checks++; if (bus.mem_addr !== 13'h0010) $display("FAIL fetch_addr: got %h expected 0010", bus.mem_addr); else passed++;
        checks++; if (bus.busy !== 1'b1) $display("FAIL fetch_busy_c1: got %b expected 1", bus.busy); else passed++;
        bus.if_req = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            checks++; if ({bus.if_done, bus.d_done} !== ((c == 4) ? 2'b10 : 2'b00))
                $display("FAIL fetch_done c%0d: got %b expected %b", c, {bus.if_done, bus.d_done}, (c == 4) ? 2'b10 : 2'b00); else passed++;
            checks++; if (bus.busy !== (c <= 4)) $display("FAIL fetch_busy c%0d: got %b expected %b", c, bus.busy, (c <= 4)); else passed++;
            checks++; if ({bus.mem_re, bus.mem_we} !== 2'b00) $display("FAIL fetch_strobe_off c%0d: got %b expected 00", c, {bus.mem_re, bus.mem_we}); else passed++;
            if (c == 4) begin
                checks++; if (bus.if_rdata !== 8'hA5) $display("FAIL fetch_rdata: got %h expected a5", bus.if_rdata); else passed++;
            end
        end
    endtask

    task automatic test_data_write();
        int we_cnt;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 13'h1F00;
        bus.d_wdata = 8'h3C;
        tick();
        checks++; if ({bus.if_gnt, bus.d_gnt} !== 2'b01) $display("FAIL write_gnt: got %b expected 01", {bus.if_gnt, bus.d_gnt}); else passed++;
        checks++; if ({bus.mem_re, bus.mem_we} !== 2'b01) $display("FAIL write_strobe: got %b expected 01", {bus.mem_re, bus.mem_we}); else passed++;
        checks++; if (bus.mem_addr !== 13'h1F00) $display("FAIL write_addr: got %h expected 1f00", bus.mem_addr); else passed++;
        checks++; if (bus.mem_wdata !== 8'h3C) $display("FAIL write_wdata: got %h expected 3c", bus.mem_wdata); else passed++;
        we_cnt = 1;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (bus.mem_we === 1'b1) we_cnt++;
            checks++; if (bus.d_done !== (c == 4)) $display("FAIL write_done c%0d: got %b expected %b", c, bus.d_done, (c == 4)); else passed++;
        end
        checks++; if (we_cnt !== 1) $display("FAIL write_we_cycles: got %0d expected 1", we_cnt); else passed++;
        checks++; if (bus.d_rdata !== 8'h00) $display("FAIL write_d_rdata: got %h expected 00", bus.d_rdata); else passed++;
        checks++; if (bus.if_rdata !== 8'hA5) $display("FAIL write_if_rdata: got %h expected a5", bus.if_rdata); else passed++;
    endtask

    task automatic test_data_read();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 13'h0123;
        tick();
        checks++; if ({bus.d_gnt, bus.mem_re, bus.mem_we} !== 3'b110) $display("FAIL dread_issue: got %b expected 110", {bus.d_gnt, bus.mem_re, bus.mem_we}); else passed++;
        bus.d_req = 1'b0;
        tick(); tick(); tick();
        checks++; if ({bus.if_done, bus.d_done} !== 2'b01) $display("FAIL dread_done: got %b expected 01", {bus.if_done, bus.d_done}); else passed++;
        checks++; if (bus.d_rdata !== 8'h97) $display("FAIL dread_rdata: got %h expected 97", bus.d_rdata); else passed++;
        checks++; if (bus.if_rdata !== 8'hA5) $display("FAIL dread_if_rdata_kept: got %h expected a5", bus.if_rdata); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.if_req  = 1'b1;
        bus.if_addr = 13'h0200;
        tick();
        checks++; if (bus.if_gnt !== 1'b1) $display("FAIL rstmid_gnt: got %b expected 1", bus.if_gnt); else passed++;
        bus.if_req = 1'b0;
        tick();
        #1 rst = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.if_gnt, bus.d_gnt, bus.if_done, bus.d_done, bus.mem_re, bus.mem_we} !== 7'b0)
            $display("FAIL rstmid_flags: got %b expected 0000000", {bus.busy, bus.if_gnt, bus.d_gnt, bus.if_done, bus.d_done, bus.mem_re, bus.mem_we}); else passed++;
        checks++; if (bus.mem_addr !== 13'h0000) $display("FAIL rstmid_addr: got %h expected 0000", bus.mem_addr); else passed++;
        checks++; if ({bus.if_rdata, bus.d_rdata} !== 16'h0000) $display("FAIL rstmid_rdata: got %h expected 0000", {bus.if_rdata, bus.d_rdata}); else passed++;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if ({bus.if_done, bus.d_done, bus.busy} !== 3'b000) $display("FAIL rstmid_no_done c%0d: got %b expected 000", c, {bus.if_done, bus.d_done, bus.busy}); else passed++;
        end
        bus.if_req  = 1'b1;
        bus.if_addr = 13'h0010;
        tick();
        checks++; if (bus.if_gnt !== 1'b1) $display("FAIL rstmid_next_gnt: got %b expected 1", bus.if_gnt); else passed++;
        bus.if_req = 1'b0;
        tick(); tick(); tick();
        checks++; if (bus.if_done !== 1'b1) $display("FAIL rstmid_next_done: got %b expected 1", bus.if_done); else passed++;
        checks++; if (bus.if_rdata !== 8'hA5) $display("FAIL rstmid_next_rdata: got %h expected a5", bus.if_rdata); else passed++;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_gnt, exp_done;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 13'h0040;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 13'h0080;
        for (int c = 1; c <= 15; c++) begin
            tick();
            exp_gnt  = (c == 1 || c == 11) ? 2'b10 : (c == 6) ? 2'b01 : 2'b00;
            exp_done = (c == 4 || c == 14) ? 2'b10 : (c == 9) ? 2'b01 : 2'b00;
            checks++; if ({bus.if_gnt, bus.d_gnt} !== exp_gnt) $display("FAIL tie_gnt c%0d: got %b expected %b", c, {bus.if_gnt, bus.d_gnt}, exp_gnt); else passed++;
            checks++; if ({bus.if_done, bus.d_done} !== exp_done) $display("FAIL tie_done c%0d: got %b expected %b", c, {bus.if_done, bus.d_done}, exp_done); else passed++;
            if (c == 4 || c == 14) begin
                checks++; if (bus.if_rdata !== 8'hF5) $display("FAIL tie_if_rdata c%0d: got %h expected f5", c, bus.if_rdata); else passed++;
            end
            if (c == 9) begin
                checks++; if (bus.d_rdata !== 8'h35) $display("FAIL tie_d_rdata: got %h expected 35", bus.d_rdata); else passed++;
            end
            if (c == 11) begin
                bus.if_req = 1'b0;
                bus.d_req  = 1'b0;
            end
        end
        checks++; if (bus.busy !== 1'b0) $display("FAIL tie_idle: got %b expected 0", bus.busy); else passed++;
    endtask

    task automatic test_late_arrival();
        logic [1:0] exp_strobe;
        bus.if_req  = 1'b1;
        bus.if_addr = 13'h0300;
        for (int c = 1; c <= 10; c++) begin
            tick();
            exp_strobe = (c == 1 || c == 6) ? 2'b10 : 2'b00;
            checks++; if ({bus.if_gnt, bus.d_gnt} !== ((c == 1) ? 2'b10 : (c == 6) ? 2'b01 : 2'b00))
                $display("FAIL late_gnt c%0d: got %b", c, {bus.if_gnt, bus.d_gnt}); else passed++;
            checks++; if ({bus.mem_re, bus.mem_we} !== exp_strobe) $display("FAIL late_strobe c%0d: got %b expected %b", c, {bus.mem_re, bus.mem_we}, exp_strobe); else passed++;
            if (c == 4) begin
                checks++; if ({bus.if_done, bus.if_rdata} !== {1'b1, 8'hB6}) $display("FAIL late_if_done: got %b/%h expected 1/b6", bus.if_done, bus.if_rdata); else passed++;
            end
            if (c == 9) begin
                checks++; if ({bus.d_done, bus.d_rdata} !== {1'b1, 8'hB0}) $display("FAIL late_d_done: got %b/%h expected 1/b0", bus.d_done, bus.d_rdata); else passed++;
            end
            if (c == 1) bus.if_req = 1'b0;
            if (c == 2) begin
                bus.d_req  = 1'b1;
                bus.d_we   = 1'b0;
                bus.d_addr = 13'h0005;
            end
            if (c == 6) bus.d_req = 1'b0;
        end
        checks++; if (bus.busy !== 1'b0) $display("FAIL late_idle: got %b expected 0", bus.busy); else passed++;
    endtask

    task automatic test_lat1();
        bus2.d_req  = 1'b1;
        bus2.d_we   = 1'b0;
        bus2.d_addr = 13'h0ABC;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) begin
                checks++; if ({bus2.d_gnt, bus2.mem_re, bus2.mem_addr} !== {2'b11, 13'h0ABC})
                    $display("FAIL lat1_issue: got %b/%b/%h expected 1/1/0abc", bus2.d_gnt, bus2.mem_re, bus2.mem_addr); else passed++;
                bus2.d_req = 1'b0;
            end
            checks++; if (bus2.d_done !== (c == 3)) $display("FAIL lat1_done c%0d: got %b expected %b", c, bus2.d_done, (c == 3)); else passed++;
            checks++; if (bus2.busy !== (c <= 3)) $display("FAIL lat1_busy c%0d: got %b expected %b", c, bus2.busy, (c <= 3)); else passed++;
            if (c == 3) begin
                checks++; if (bus2.d_rdata !== 8'h03) $display("FAIL lat1_rdata: got %h expected 03", bus2.d_rdata); else passed++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0;  bus.if_addr = '0;  bus.d_req = 1'b0;  bus.d_we = 1'b0;  bus.d_addr = '0;  bus.d_wdata = '0;
        bus2.if_req = 1'b0; bus2.if_addr = '0; bus2.d_req = 1'b0; bus2.d_we = 1'b0; bus2.d_addr = '0; bus2.d_wdata = '0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_single_fetch();
        test_data_write();
        test_data_read();
        test_reset_mid();
        test_simultaneous();
        test_late_arrival();
        test_lat1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
